// File: rtl/sisp_job_sequencer_pkg.sv
// Shared types and constants for the SISP job sequencer: FSM states, context
// addresses, mode codes and the replay-count saturation helper.
package sisp_job_sequencer_pkg;

   localparam int unsigned CTX_MODE_ADDR   = 0;
   localparam int unsigned CTX_RESULT_ADDR = 121;

   localparam logic [5:0] MODE_CAND_HIST = 6'd1;
   localparam logic [5:0] MODE_DISTANCE  = 6'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLRBUF,
      ST_CFG,
      ST_ARM,
      ST_WAIT,
      ST_RD,
      ST_CAP,
      ST_DONE
   } state_t;

   function automatic int unsigned sat_ncfg(input int unsigned n, input int unsigned depth);
      return (n > depth) ? depth : n;
   endfunction

endpackage

// File: rtl/sisp_job_sequencer_cfg_table.sv
// Context-write table: DEPTH x {addr, data} register file, one synchronous
// write port, one asynchronous read port, cleared by reset.
module sisp_job_sequencer_cfg_table #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              we,
   input  logic [IDX_W-1:0]  widx,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  ridx,
   output logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_mem[i] <= '0;
            data_mem[i] <= '0;
         end
      end else if (we) begin
         addr_mem[widx] <= waddr;
         data_mem[widx] <= wdata;
      end
   end

   assign raddr = addr_mem[ridx];
   assign rdata = data_mem[ridx];

endmodule

// File: rtl/sisp_job_sequencer.sv
// Host-side SISP job sequencer: replays the context table, issues the mode,
// waits for DataOutReady (with timeout) and optionally captures one result word.
module sisp_job_sequencer
   import sisp_job_sequencer_pkg::*;
#(
   parameter int unsigned CFG_DEPTH   = 16,
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned CADDR_W     = 8,
   parameter int unsigned TIMEOUT_CYC = 65535,
   parameter int unsigned RESULT_ADDR = CTX_RESULT_ADDR,
   parameter int unsigned IDX_W       = $clog2(CFG_DEPTH),
   parameter int unsigned NCFG_W      = $clog2(CFG_DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               stall_i,
   input  logic               cfg_we_i,
   input  logic [IDX_W-1:0]   cfg_idx_i,
   input  logic [CADDR_W-1:0] cfg_addr_i,
   input  logic [DATA_W-1:0]  cfg_data_i,
   input  logic               job_valid_i,
   output logic               job_ready_o,
   input  logic [5:0]         job_mode_i,
   input  logic [NCFG_W-1:0]  job_ncfg_i,
   input  logic               job_rd_result_i,
   output logic [CADDR_W-1:0] sisp_ctx_addr_o,
   output logic [DATA_W-1:0]  sisp_data_o,
   output logic               sisp_data_ready_o,
   output logic               sisp_gateclk_o,
   output logic               sisp_reset_buffer_o,
   input  logic [DATA_W-1:0]  sisp_data_i,
   input  logic               sisp_out_ready_i,
   output logic               done_valid_o,
   input  logic               done_ready_i,
   output logic [DATA_W-1:0]  done_result_o,
   output logic               done_timeout_o,
   output logic               busy_o
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   state_t              st_q, st_nx;
   logic [IDX_W-1:0]    idx_q, idx_nx;
   logic [NCFG_W-1:0]   n_q, n_nx;
   logic [5:0]          mode_q, mode_nx;
   logic                rd_q, rd_nx;
   logic [TW-1:0]       wcnt_q, wcnt_nx;
   logic                to_nx;
   logic [DATA_W-1:0]   res_nx;
   logic [CADDR_W-1:0]  addr_nx, tbl_addr;
   logic [DATA_W-1:0]   data_nx, tbl_data;

   sisp_job_sequencer_cfg_table #(
      .DEPTH  (CFG_DEPTH),
      .ADDR_W (CADDR_W),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_cfg_table (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (cfg_we_i && (st_q == ST_IDLE)),
      .widx    (cfg_idx_i),
      .waddr   (cfg_addr_i),
      .wdata   (cfg_data_i),
      .ridx    (idx_nx),
      .raddr   (tbl_addr),
      .rdata   (tbl_data)
   );

   // Next-state view; outputs are registered from it so each bus value
   // appears during the cycle its state is occupied.
   always_comb begin
      st_nx   = st_q;
      idx_nx  = idx_q;
      n_nx    = n_q;
      mode_nx = mode_q;
      rd_nx   = rd_q;
      wcnt_nx = wcnt_q;
      to_nx   = done_timeout_o;
      res_nx  = done_result_o;
      if (!stall_i || (st_q == ST_DONE)) begin
         unique case (st_q)
            ST_IDLE: if (job_valid_i) begin
               st_nx   = ST_CLRBUF;
               mode_nx = job_mode_i;
               n_nx    = NCFG_W'(sat_ncfg(32'(job_ncfg_i), CFG_DEPTH));
               rd_nx   = job_rd_result_i;
               to_nx   = 1'b0;
               res_nx  = '0;
            end
            ST_CLRBUF: begin
               idx_nx = '0;
               st_nx  = (n_q == '0) ? ST_ARM : ST_CFG;
            end
            ST_CFG: begin
               if (NCFG_W'(idx_q) + NCFG_W'(1) == n_q) st_nx = ST_ARM;
               else                                     idx_nx = idx_q + IDX_W'(1);
            end
            ST_ARM: begin
               st_nx   = ST_WAIT;
               wcnt_nx = TW'(1);
            end
            ST_WAIT: begin
               if (sisp_out_ready_i) begin
                  st_nx = rd_q ? ST_RD : ST_DONE;
               end else if (wcnt_q == TW'(TIMEOUT_CYC)) begin
                  st_nx = ST_DONE;
                  to_nx = 1'b1;
               end else begin
                  wcnt_nx = wcnt_q + TW'(1);
               end
            end
            ST_RD: st_nx = ST_CAP;
            ST_CAP: begin
               res_nx = sisp_data_i;
               st_nx  = ST_DONE;
            end
            ST_DONE: if (done_ready_i) st_nx = ST_IDLE;
            default: st_nx = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      addr_nx = '0;
      data_nx = '0;
      unique case (st_nx)
         ST_CFG: begin
            addr_nx = tbl_addr;
            data_nx = tbl_data;
         end
         ST_ARM, ST_WAIT: begin
            addr_nx = CADDR_W'(CTX_MODE_ADDR);
            data_nx = DATA_W'(mode_nx);
         end
         ST_RD, ST_CAP: addr_nx = CADDR_W'(RESULT_ADDR);
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_q                <= ST_IDLE;
         idx_q               <= '0;
         n_q                 <= '0;
         mode_q              <= '0;
         rd_q                <= 1'b0;
         wcnt_q              <= '0;
         job_ready_o         <= 1'b1;
         busy_o              <= 1'b0;
         sisp_data_ready_o   <= 1'b0;
         sisp_reset_buffer_o <= 1'b0;
         sisp_gateclk_o      <= 1'b0;
         sisp_ctx_addr_o     <= '0;
         sisp_data_o         <= '0;
         done_valid_o        <= 1'b0;
         done_result_o       <= '0;
         done_timeout_o      <= 1'b0;
      end else begin
         st_q                <= st_nx;
         idx_q               <= idx_nx;
         n_q                 <= n_nx;
         mode_q              <= mode_nx;
         rd_q                <= rd_nx;
         wcnt_q              <= wcnt_nx;
         job_ready_o         <= (st_nx == ST_IDLE);
         busy_o              <= (st_nx != ST_IDLE);
         sisp_data_ready_o   <= (st_nx != ST_IDLE);
         sisp_reset_buffer_o <= (st_nx == ST_CLRBUF);
         sisp_gateclk_o      <= (st_nx != ST_IDLE) && !stall_i;
         sisp_ctx_addr_o     <= addr_nx;
         sisp_data_o         <= data_nx;
         done_valid_o        <= (st_nx == ST_DONE);
         done_result_o       <= res_nx;
         done_timeout_o      <= to_nx;
      end
   end

endmodule

// File: tb/tb_sisp_job_sequencer.sv
// Scoreboard bench for sisp_job_sequencer: expected bus traces and completions
// are queued per job and compared as the DUT produces them.
module tb_sisp_job_sequencer;
   import sisp_job_sequencer_pkg::*;

   localparam int unsigned TMO = 100;
   localparam logic [63:0] RES_VAL = 64'h1F217D;

   logic        clk = 1'b0;
   logic        reset_n, stall_i, cfg_we_i, job_valid_i, job_ready_o, job_rd_result_i;
   logic [3:0]  cfg_idx_i;
   logic [7:0]  cfg_addr_i, sisp_ctx_addr_o;
   logic [63:0] cfg_data_i, sisp_data_o, sisp_data_i, done_result_o;
   logic [5:0]  job_mode_i;
   logic [4:0]  job_ncfg_i;
   logic        sisp_data_ready_o, sisp_gateclk_o, sisp_reset_buffer_o, sisp_out_ready_i;
   logic        done_valid_o, done_ready_i, done_timeout_o, busy_o;

   always #5 clk = ~clk;

   sisp_job_sequencer #(.TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .reset_n(reset_n), .stall_i(stall_i),
      .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
      .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_mode_i(job_mode_i),
      .job_ncfg_i(job_ncfg_i), .job_rd_result_i(job_rd_result_i),
      .sisp_ctx_addr_o(sisp_ctx_addr_o), .sisp_data_o(sisp_data_o),
      .sisp_data_ready_o(sisp_data_ready_o), .sisp_gateclk_o(sisp_gateclk_o),
      .sisp_reset_buffer_o(sisp_reset_buffer_o), .sisp_data_i(sisp_data_i),
      .sisp_out_ready_i(sisp_out_ready_i), .done_valid_o(done_valid_o),
      .done_ready_i(done_ready_i), .done_result_o(done_result_o),
      .done_timeout_o(done_timeout_o), .busy_o(busy_o)
   );

   // SISP model: result word is returned whenever the result address is on the bus.
   assign sisp_data_i = (sisp_ctx_addr_o == 8'd121) ? RES_VAL : 64'hBAD0_BAD0_BAD0_BAD0;

   int n_checks = 0;
   int n_err    = 0;

   logic [7:0]  sh_a [16];
   logic [63:0] sh_d [16];
   logic [73:0] trace_q [$];
   logic [64:0] done_q  [$];
   bit          mon_en = 1'b0;
   bit          stale  = 1'b0;
   logic [5:0]  cur_mode = '0;
   int          ready_at = 0;
   int          mode_cnt = 0;
   logic        in_mode;
   logic [73:0] tr_exp;

   task automatic check(input string tag, input logic [79:0] act, input logic [79:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Ready model: raises DataOutReady during the ready_at-th {0,mode} cycle;
   // with stale set it also drives ready while table entries are on the bus.
   always @(negedge clk) begin
      in_mode = sisp_data_ready_o && !sisp_reset_buffer_o && (sisp_ctx_addr_o == 8'd0)
                && (sisp_data_o == {58'd0, cur_mode});
      if (sisp_reset_buffer_o) mode_cnt = 0;
      else if (in_mode)        mode_cnt++;
      sisp_out_ready_i = (in_mode && (ready_at != 0) && (mode_cnt >= ready_at))
                         || (stale && sisp_data_ready_o && (sisp_ctx_addr_o != 8'd0)
                             && (sisp_ctx_addr_o != 8'd121));
   end

   always @(negedge clk) begin
      if (mon_en && reset_n && sisp_data_ready_o && !done_valid_o) begin
         tr_exp = (trace_q.size() != 0) ? trace_q.pop_front() : '1;
         check("trace", {sisp_gateclk_o, sisp_reset_buffer_o, sisp_ctx_addr_o, sisp_data_o}, tr_exp);
      end
   end

   task automatic prog(input int idx, input logic [7:0] a, input logic [63:0] d);
      @(negedge clk);
      cfg_we_i = 1'b1; cfg_idx_i = idx[3:0]; cfg_addr_i = a; cfg_data_i = d;
      @(negedge clk);
      cfg_we_i = 1'b0;
      sh_a[idx] = a;
      sh_d[idx] = d;
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_job_ready"}, job_ready_o, 1);
      check({pfx, "_busy"}, busy_o, 0);
      check({pfx, "_bus"}, {sisp_data_ready_o, sisp_reset_buffer_o, sisp_gateclk_o, sisp_ctx_addr_o, sisp_data_o}, 0);
      check({pfx, "_done"}, {done_valid_o, done_timeout_o, done_result_o}, 0);
   endtask

   task automatic run_job(input logic [5:0] mode, input logic [4:0] ncfg, input bit rd,
                          input int rdy, input bit to, input logic [63:0] res, input int hold,
                          input bit do_stall, input bit do_we, input bit st);
      int n, mc, c;
      bit stalled;
      logic [64:0] dexp;
      n  = (ncfg > 5'd16) ? 16 : int'(ncfg);
      mc = to ? int'(TMO) + 1 : rdy;
      trace_q.push_back({1'b1, 1'b1, 8'd0, 64'd0});
      for (int i = 0; i < n; i++) begin
         trace_q.push_back({1'b1, 1'b0, sh_a[i], sh_d[i]});
         if (do_stall && i == 1)
            repeat (4) trace_q.push_back({1'b0, 1'b0, sh_a[i], sh_d[i]});
      end
      repeat (mc) trace_q.push_back({1'b1, 1'b0, 8'd0, {58'd0, mode}});
      if (rd && !to) repeat (2) trace_q.push_back({1'b1, 1'b0, 8'd121, 64'd0});
      done_q.push_back({to, res});
      cur_mode = mode;
      ready_at = to ? 0 : rdy;
      stale    = st;

      @(negedge clk);
      job_valid_i = 1'b1; job_mode_i = mode; job_ncfg_i = ncfg; job_rd_result_i = rd;
      @(negedge clk);
      job_valid_i = 1'b0;
      c = 0;
      stalled = 1'b0;
      while (!done_valid_o && c < 500) begin
         if (do_stall && !stalled && sisp_data_ready_o && sisp_ctx_addr_o == sh_a[1]) begin
            stalled = 1'b1;
            stall_i = 1'b1;
            repeat (4) @(negedge clk);
            stall_i = 1'b0;
         end
         cfg_we_i   = do_we && sisp_data_ready_o && (sisp_ctx_addr_o == 8'd0)
                      && (sisp_data_o == {58'd0, mode});
         cfg_idx_i  = '0;
         cfg_addr_i = 8'hEE;
         cfg_data_i = '1;
         @(negedge clk);
         c++;
      end
      cfg_we_i = 1'b0;
      stale    = 1'b0;
      check("done_seen", done_valid_o, 1);
      dexp = done_q.pop_front();
      for (int h = 0; h < hold; h++) begin
         check("hold_valid", done_valid_o, 1);
         check("hold_result", done_result_o, dexp[63:0]);
         check("hold_timeout", done_timeout_o, dexp[64]);
         check("hold_job_ready", job_ready_o, 0);
         @(negedge clk);
      end
      check("done_result", done_result_o, dexp[63:0]);
      check("done_timeout", done_timeout_o, dexp[64]);
      check("done_bus", {sisp_ctx_addr_o, sisp_data_o}, 0);
      done_ready_i = 1'b1;
      @(posedge clk);
      #1;
      done_ready_i = 1'b0;
      check("done_valid_clr", done_valid_o, 0);
      check("job_ready_back", job_ready_o, 1);
      check("trace_left", trace_q.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0; stall_i = 1'b0; cfg_we_i = 1'b0; cfg_idx_i = '0; cfg_addr_i = '0;
      cfg_data_i = '0; job_valid_i = 1'b0; job_mode_i = '0; job_ncfg_i = '0;
      job_rd_result_i = 1'b0; done_ready_i = 1'b0;
      for (int i = 0; i < 16; i++) begin sh_a[i] = '0; sh_d[i] = '0; end
      repeat (2) @(negedge clk);
      check_reset_vals("por");
      reset_n = 1'b1;

      prog(0, 8'd106, 64'd9);
      prog(1, 8'd107, 64'd1);
      prog(2, 8'd108, 64'h1_0000_5019);

      // Abort a running job with a mid-cycle asynchronous reset.
      cur_mode = MODE_DISTANCE;
      ready_at = 0;
      @(negedge clk);
      job_valid_i = 1'b1; job_mode_i = MODE_DISTANCE; job_ncfg_i = 5'd3; job_rd_result_i = 1'b0;
      @(negedge clk);
      job_valid_i = 1'b0;
      repeat (8) @(negedge clk);
      check("pre_reset_busy", busy_o, 1);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1 check_reset_vals("async");
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 16; i++) begin sh_a[i] = '0; sh_d[i] = '0; end
      mon_en = 1'b1;

      run_job(MODE_CAND_HIST, 5'd2, 1'b0, 3, 1'b0, 64'd0, 0, 1'b0, 1'b0, 1'b0);

      prog(0, 8'd106, 64'd9);
      prog(1, 8'd107, 64'd1);
      prog(2, 8'd108, 64'h1_0000_5019);

      run_job(MODE_CAND_HIST, 5'd3, 1'b0, 21, 1'b0, 64'd0, 0, 1'b0, 1'b0, 1'b0);
      run_job(MODE_DISTANCE,  5'd0, 1'b1, 5,  1'b0, RES_VAL, 0, 1'b0, 1'b0, 1'b0);
      run_job(MODE_CAND_HIST, 5'd3, 1'b1, 0,  1'b1, 64'd0, 0, 1'b0, 1'b0, 1'b0);
      run_job(MODE_DISTANCE,  5'd3, 1'b1, 3,  1'b0, RES_VAL, 0, 1'b1, 1'b0, 1'b0);
      run_job(MODE_CAND_HIST, 5'd3, 1'b0, 6,  1'b0, 64'd0, 5, 1'b0, 1'b0, 1'b0);
      run_job(MODE_DISTANCE,  5'd3, 1'b0, 8,  1'b0, 64'd0, 0, 1'b0, 1'b1, 1'b0);
      run_job(MODE_CAND_HIST, 5'd3, 1'b0, 4,  1'b0, 64'd0, 0, 1'b0, 1'b0, 1'b0);
      run_job(MODE_CAND_HIST, 5'd3, 1'b0, 4,  1'b0, 64'd0, 0, 1'b0, 1'b0, 1'b1);
      run_job(MODE_DISTANCE,  5'd31, 1'b1, 2, 1'b0, RES_VAL, 2, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
